// File: rtl/matrix_unloader_if.sv
// Handshake and data bundle between the matrix read-out block and its host/consumer.
// Latency: none; this is only a set of wires.
// Backpressure: out_ready from the consumer stalls the element stream.
interface matrix_unloader_if #(
  parameter int DATA_W = 4,
  parameter int N      = 2
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic                      start;
  logic [N*N*DATA_W-1:0]     mat_in;
  logic                      out_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [RW-1:0]             out_row;
  logic [RW-1:0]             out_col;
  logic                      out_last;
  logic                      busy;
  logic                      done;

  // Unloader side: takes the matrix and start, drives the element stream.
  modport master (
    input  start, mat_in, out_ready,
    output out_valid, out_data, out_row, out_col, out_last, busy, done
  );

  // Host/consumer side.
  modport slave (
    output start, mat_in, out_ready,
    input  out_valid, out_data, out_row, out_col, out_last, busy, done
  );
endinterface

// File: rtl/matrix_unloader.sv
// Snapshots an N x N matrix on start and streams it out row-major, one element per handshake.
// Latency: first element valid the cycle after start; done pulses the cycle after the last handshake.
// Backpressure: out_ready low freezes every out_* output and the element index indefinitely.
module matrix_unloader #(
  parameter int DATA_W = 4,
  parameter int N      = 2
) (
  input  logic               clk,
  input  logic               clear,
  matrix_unloader_if.master  bus
);

  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = NE * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     row_q, row_d;
  logic [RW-1:0]     col_q, col_d;
  logic [BW-1:0]     buf_q, buf_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hs;
  logic [IW-1:0]     idx_inc;

  assign hs      = valid_q & bus.out_ready;
  assign idx_inc = idx_q + IW'(1);

  // Next-state and next-output logic; outputs are computed one cycle ahead so every port is a flop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          buf_d   = bus.mat_in;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          data_d  = bus.mat_in[DATA_W-1:0];
          last_d  = (NE == 1);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        if (hs) begin
          if (last_q) begin
            // Final element accepted: drop valid and clear the element fields.
            state_d = DONE;
            valid_d = 1'b0;
            data_d  = '0;
            row_d   = '0;
            col_d   = '0;
            last_d  = 1'b0;
            idx_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            // Row/column tracked as counters so no divider is needed for idx / N.
            idx_d  = idx_inc;
            data_d = buf_q[int'(idx_inc) * DATA_W +: DATA_W];
            last_d = (idx_inc == IW'(NE - 1));
            if (col_q == RW'(N - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + RW'(1);
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, snapshot buffer and registered outputs; clear aborts any transfer immediately.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_matrix_unloader.sv
// Bench for matrix_unloader: N=2 and N=4 instances checked every cycle against a queue/array model.
// Latency: model outputs are compared on the falling edge, half a cycle after each update.
// Backpressure: out_ready is driven directly and randomised in the soak phase.
module tb_matrix_unloader;

  logic clk;
  logic clear;

  matrix_unloader_if #(.DATA_W(4), .N(2)) if2 ();
  matrix_unloader_if #(.DATA_W(4), .N(4)) if4 ();

  matrix_unloader #(.DATA_W(4), .N(2)) u_dut2 (.clk(clk), .clear(clear), .bus(if2));
  matrix_unloader #(.DATA_W(4), .N(4)) u_dut4 (.clk(clk), .clear(clear), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Element record: {data, row, col, last}
  function automatic logic [31:0] pk(input int d, input int r, input int c, input bit l);
    return {11'b0, 4'(d), 8'(r), 8'(c), l};
  endfunction

  // Whole-port snapshot: {valid, data, row, col, last, busy, done}
  function automatic logic [31:0] got2();
    return {8'b0, if2.out_valid, if2.out_data, 8'(if2.out_row), 8'(if2.out_col),
            if2.out_last, if2.busy, if2.done};
  endfunction

  function automatic logic [31:0] got4();
    return {8'b0, if4.out_valid, if4.out_data, 8'(if4.out_row), 8'(if4.out_col),
            if4.out_last, if4.busy, if4.done};
  endfunction

  // Expected port snapshot from the model phase (0 idle, 1 sending, 2 done) and position.
  function automatic logic [31:0] expw(input int n, input int ph, input int pos, input logic [3:0] d);
    logic v;
    v = (ph == 1);
    return {8'b0, v, v ? d : 4'h0, v ? 8'(pos / n) : 8'h0, v ? 8'(pos % n) : 8'h0,
            v && (pos == n * n - 1), ph != 0, ph == 2};
  endfunction

  // Reference model: list of snapshotted elements plus a read position.
  int         ph2 = 0, pos2 = 0, ph4 = 0, pos4 = 0;
  logic [3:0] el2 [0:63];
  logic [3:0] el4 [0:63];

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      ph2 = 0; pos2 = 0;
    end else begin
      case (ph2)
        0: if (if2.start) begin
             for (int e = 0; e < 4; e++) el2[e] = if2.mat_in[e*4 +: 4];
             ph2 = 1; pos2 = 0;
           end
        1: if (if2.out_ready) begin
             pos2++;
             if (pos2 == 4) ph2 = 2;
           end
        default: ph2 = 0;
      endcase
    end
  end

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      ph4 = 0; pos4 = 0;
    end else begin
      case (ph4)
        0: if (if4.start) begin
             for (int e = 0; e < 16; e++) el4[e] = if4.mat_in[e*4 +: 4];
             ph4 = 1; pos4 = 0;
           end
        1: if (if4.out_ready) begin
             pos4++;
             if (pos4 == 16) ph4 = 2;
           end
        default: ph4 = 0;
      endcase
    end
  end

  // Monitor: per-cycle model comparison plus handshake/done/busy logs for directed tests.
  logic [31:0] hs2_q [$];
  logic [31:0] hs4_q [$];
  int          vrise_q [$];
  int          done_q [$];
  int          done2_cnt = 0, busy2_cnt = 0, ovl = 0, cyc = 0;
  logic        pv2 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    chk("cycle_n2", got2(), expw(2, ph2, pos2, el2[pos2]));
    chk("cycle_n4", got4(), expw(4, ph4, pos4, el4[pos4]));
    if (if2.out_valid && if2.out_ready)
      hs2_q.push_back(pk(int'(if2.out_data), int'(if2.out_row), int'(if2.out_col), if2.out_last));
    if (if4.out_valid && if4.out_ready)
      hs4_q.push_back(pk(int'(if4.out_data), int'(if4.out_row), int'(if4.out_col), if4.out_last));
    if (if2.done) begin
      done2_cnt++;
      done_q.push_back(cyc);
    end
    if (if2.busy) busy2_cnt++;
    if (if2.out_valid && !pv2) vrise_q.push_back(cyc);
    if (if2.done && if2.out_valid) ovl++;
    pv2 = if2.out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    hs2_q.delete();
    hs4_q.delete();
    vrise_q.delete();
    done_q.delete();
    done2_cnt = 0;
    busy2_cnt = 0;
    ovl       = 0;
  endtask

  // order holds the expected element values, first element in the top nibble.
  task automatic check_stream2(input string tag, input logic [15:0] order);
    chk({tag, "_len"}, hs2_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < hs2_q.size())
        chk(tag, hs2_q[i], pk(int'(order[(3-i)*4 +: 4]), i / 2, i % 2, i == 3));
    end
  endtask

  initial begin
    clear         = 1'b1;
    if2.start     = 1'b0;
    if2.mat_in    = '0;
    if2.out_ready = 1'b0;
    if4.start     = 1'b0;
    if4.mat_in    = '0;
    if4.out_ready = 1'b0;

    #2;
    chk("reset_n2", got2(), 32'h0);
    chk("reset_n4", got4(), 32'h0);
    repeat (2) @(posedge clk);
    #3 clear = 1'b0;
    step();

    // Basic stream
    clr_mon();
    if2.mat_in = 16'hA5C3; if2.out_ready = 1'b1; if2.start = 1'b1;
    step();
    if2.start = 1'b0;
    repeat (10) step();
    check_stream2("basic", 16'h3C5A);
    chk("basic_done", done2_cnt, 1);
    chk("basic_busy", busy2_cnt, 5);

    // Backpressure while C is presented
    clr_mon();
    if2.start = 1'b1;
    step();
    if2.start = 1'b0;
    step();
    if2.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {if2.out_valid, pk(int'(if2.out_data), int'(if2.out_row), int'(if2.out_col), if2.out_last)},
          {1'b1, pk(12, 0, 1, 1'b0)});
      @(posedge clk);
      #1;
    end
    if2.out_ready = 1'b1;
    repeat (8) step();
    check_stream2("bp", 16'h3C5A);
    chk("bp_done", done2_cnt, 1);

    // Snapshot and start ignored while sending
    clr_mon();
    if2.mat_in = 16'h1234; if2.start = 1'b1;
    step();
    if2.start = 1'b0; if2.mat_in = 16'hFFFF;
    step();
    if2.start = 1'b1;
    step();
    if2.start = 1'b0;
    repeat (8) step();
    check_stream2("snap", 16'h4321);
    chk("snap_done", done2_cnt, 1);

    // Asynchronous clear after two handshakes
    clr_mon();
    if2.mat_in = 16'hA5C3; if2.start = 1'b1;
    step();
    if2.start = 1'b0;
    step();
    step();
    #2 clear = 1'b1;
    #1;
    chk("arst_zero", got2(), 32'h0);
    chk("arst_hs_before", hs2_q.size(), 2);
    repeat (3) @(posedge clk);
    #3 clear = 1'b0;
    repeat (3) step();
    chk("arst_nodone", done2_cnt, 0);
    clr_mon();
    if2.start = 1'b1;
    step();
    if2.start = 1'b0;
    repeat (8) step();
    check_stream2("arst_restart", 16'h3C5A);

    // Back-to-back starts
    clr_mon();
    if2.out_ready = 1'b1; if2.start = 1'b1;
    repeat (20) step();
    if2.start = 1'b0;
    repeat (8) step();
    chk("b2b_ndone", done_q.size() >= 2, 1);
    if (done_q.size() >= 1 && vrise_q.size() >= 2)
      chk("b2b_gap", vrise_q[1] - done_q[0], 2);
    else
      chk("b2b_events", vrise_q.size(), 2);
    chk("b2b_overlap", ovl, 0);

    // N=4 sweep
    clr_mon();
    for (int e = 0; e < 16; e++) if4.mat_in[e*4 +: 4] = 4'(e);
    if4.out_ready = 1'b1; if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    repeat (20) step();
    chk("sweep_len", hs4_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < hs4_q.size())
        chk("sweep_el", hs4_q[i], pk(i, i / 4, i % 4, i == 15));
    end

    // Random soak: both instances checked every cycle by the model
    for (int c = 0; c < 400; c++) begin
      if2.start     = ($urandom_range(0, 5) == 0);
      if2.out_ready = ($urandom_range(0, 3) != 0);
      if2.mat_in    = 16'($urandom);
      if4.start     = ($urandom_range(0, 5) == 0);
      if4.out_ready = ($urandom_range(0, 3) != 0);
      if4.mat_in    = {$urandom, $urandom};
      step();
    end
    if2.start = 1'b0; if2.out_ready = 1'b1;
    if4.start = 1'b0; if4.out_ready = 1'b1;
    repeat (25) step();
    chk("final_idle_n2", got2(), 32'h0);
    chk("final_idle_n4", got4(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
